gpu_frame_loader: RTL and testbench
===================================

// Module: gpu_frame_loader
// PURPOSE
//  Feeds the gpu's rectangle-table load port: on a frame-start request, reads WORDS
//  consecutive 16-bit words from the shared video RAM starting at base_addr. Streams
//  them to the gpu as a gapless we/mem_din burst, one word per pixel_clk.
//  Sits between the dual-port RAM's read port and gpu.we / gpu.mem_din.
//  Runs during vertical blank, while the CPU reports idle.
// PARAMETERS
//  WORDS   384  words per burst (64 rects x 6 words); must be >= 2
//  ADDR_W  16   RAM address width
// PORTS
//  pixel_clk  in   1       single clock, all logic rising-edge
//  reset      in   1       asynchronous, active-high
//  start      in   1       request a burst; sampled only in IDLE
//  cpu_idle   in   1       start is accepted only while cpu_idle=1
//  abort      in   1       synchronous cancel of a running burst
//  base_addr  in   ADDR_W  first RAM word; latched when start is accepted
//  mem_addr   out  ADDR_W  RAM read address (RAM has 1-cycle registered read)
//  mem_dout   in   16      RAM read data for the address of the previous cycle
//  gpu_we     out  1       load strobe to gpu.we
//  gpu_din    out  16      load data to gpu.mem_din (= mem_dout, combinational)
//  busy       out  1       burst in progress
//  done       out  1       1-cycle pulse after the last word
// BEHAVIOUR
//  - Reset (async) values: state=IDLE, mem_addr=0, gpu_we=0, busy=0, done=0, count=0.
//    Reset mid-burst truncates the burst immediately and produces no done pulse.
//  - FSM states: IDLE -> FETCH -> STREAM -> FINISH -> IDLE.
//  - IDLE -> FETCH on an edge E0 where start=1 and cpu_idle=1.
//    At E0: latch base_addr, set mem_addr=base, count=0, busy=1.
//  - FETCH -> STREAM at E1: gpu_we=1, mem_addr=base+1.
//    gpu_din then carries ram[base].
//  - STREAM: at each edge, count+=1 and mem_addr+=1.
//    Word k (ram[base+k]) is on gpu_din while gpu_we=1 in the (k+1)-th we cycle.
//    gpu_we stays high for exactly WORDS consecutive cycles, with no bubbles.
//  - STREAM -> FINISH at the edge that retires word WORDS-1.
//    In FINISH: gpu_we=0, busy=0, done=1 for exactly one cycle.
//    The next edge returns to IDLE. mem_addr holds its last value.
//  - Address arithmetic is modulo 2^ADDR_W: base near the top wraps to 0, with no error.
//  - start or base_addr changes while busy are ignored; no queueing.
//    A start that is high during FINISH is ignored.
//    A new start is accepted no earlier than the first IDLE cycle.
//  - abort=1 in FETCH or STREAM: at that edge go to IDLE with gpu_we=0, busy=0, done=0.
//    Words already streamed stay written in the gpu. abort in IDLE or FINISH has no effect.
//    abort has priority over the end-of-burst transition.
//  - start=1 with cpu_idle=0: stay in IDLE. The request is not remembered.
//  - Latency: start accepted at E0 -> first gpu_we cycle after E1 -> done high after E(WORDS+1).
// CONFIGURATION
//  LOADER_CHECKSUM_EN
//   - Defined: adds output checksum[15:0].
//     Cleared at start acceptance; adds gpu_din (mod 2^16) on every gpu_we cycle.
//     Valid and held from the done pulse until the next accepted start.
//     Reset value is 0. An aborted burst leaves the partial sum.
//   - Undefined: port and adder are absent; all other behaviour is identical.
// TESTING
//  1 RAM[i]=i+0x100, base=0, start with cpu_idle=1 -> 384 consecutive we cycles;
//    gpu_din = 0x100..0x27F in order; one done pulse; busy low afterwards.
//  2 base=0xFF00 (ADDR_W=16) -> mem_addr runs 0xFF00..0xFFFF, then 0x0000..0x007F; no gap in we.
//  3 start pulsed at word 10 and in FINISH -> no second burst; exactly one done;
//    start with cpu_idle=0 -> mem_addr and we unchanged.
//  4 abort at the 100th we cycle -> gpu_we=0 next cycle; busy=0; done never pulses;
//    a fresh start afterwards yields a full 384-word burst.
//  5 reset asserted asynchronously mid-STREAM (between edges) -> gpu_we, busy and
//    mem_addr drop to 0 immediately; release then start -> normal burst.
//  6 (LOADER_CHECKSUM_EN) RAM all 0x0001 -> checksum=0x0180 at done;
//    RAM all 0xFFFF -> checksum=0xFE80.

Source files
------------

// File: rtl/gpu_frame_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpu_frame_loader_if : RAM read port + gpu load port bundle       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface gpu_frame_loader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_dout;
  logic              gpu_we;
  logic [15:0]       gpu_din;

  modport master (
    output mem_addr,
    input  mem_dout,
    output gpu_we,
    output gpu_din
  );

  modport slave (
    input  mem_addr,
    output mem_dout,
    input  gpu_we,
    input  gpu_din
  );
endinterface
`default_nettype wire

// File: rtl/gpu_frame_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpu_frame_loader : streams WORDS RAM words to the gpu load port  |
// | Optional LOADER_CHECKSUM_EN adds a 16-bit burst checksum output. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module gpu_frame_loader #(
  parameter int WORDS  = 384,
  parameter int ADDR_W = 16
) (
  input  wire logic              pixel_clk,
  input  wire logic              reset,
  input  wire logic              start,
  input  wire logic              cpu_idle,
  input  wire logic              abort,
  input  wire logic [ADDR_W-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0]            checksum,
`endif
  gpu_frame_loader_if.master     bus
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_last;

  assign w_accept    = (r_state == S_IDLE) && start && cpu_idle;
  assign w_last      = (r_count == C_LAST);
  assign bus.gpu_din = bus.mem_dout;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort wins over the end-of-burst transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_FETCH;
      S_FETCH:  w_next = abort ? S_IDLE : S_STREAM;
      S_STREAM: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gpu_we = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_FETCH:  busy = 1'b1;
      S_STREAM: begin
        busy       = 1'b1;
        bus.gpu_we = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default:  ;
    endcase
  end

  // mem_addr runs one word ahead of gpu_din because of the registered RAM read
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      bus.mem_addr <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            bus.mem_addr <= base_addr;
            r_count      <= '0;
          end
        end
        S_FETCH: begin
          if (!abort) begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
          end
        end
        S_STREAM: begin
          if (!abort && !w_last) begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            r_count      <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (w_accept) begin
      checksum <= '0;
    end else if (r_state == S_STREAM) begin
      checksum <= checksum + bus.gpu_din;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpu_frame_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gpu_frame_loader : randomized self-checking bench             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_gpu_frame_loader;
  localparam int WORDS  = 384;
  localparam int ADDR_W = 16;

  logic              pixel_clk = 1'b0;
  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic              cpu_idle  = 1'b0;
  logic              abort     = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  gpu_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  gpu_frame_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .start     (start),
    .cpu_idle  (cpu_idle),
    .abort     (abort),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
`ifdef LOADER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .bus       (bus)
  );

  logic [15:0] ram [0:(1<<ADDR_W)-1];

  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) bus.mem_dout <= ram[bus.mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]       cap_din [$];
  logic [ADDR_W-1:0] cap_addr[$];
  int   cap_done, cap_gaps, cap_first_we, cap_done_at;
  logic cap_end_busy, cap_end_we;

  function automatic logic [15:0] exp_word(input logic [ADDR_W-1:0] b, input int k);
    logic [ADDR_W-1:0] a;
    a = b + ADDR_W'(k);
    return ram[a];
  endfunction

  function automatic logic [15:0] exp_sum(input logic [ADDR_W-1:0] b, input int n);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + exp_word(b, k);
    return s;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'(i + 16'h0100);
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'($urandom);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = v;
  endtask

  // Leaves the bench at the negedge following the accepting edge; base_addr is then scrambled.
  task automatic launch(input logic [ADDR_W-1:0] b);
    @(negedge pixel_clk);
    start     = 1'b1;
    cpu_idle  = 1'b1;
    base_addr = b;
    @(negedge pixel_clk);
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
  endtask

  task automatic capture(input int cycles, input int start_we, input bit start_on_done,
                         input int abort_we);
    int last_we;
    cap_din.delete();
    cap_addr.delete();
    cap_done = 0; cap_gaps = 0; cap_first_we = -1; cap_done_at = -1; last_we = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge pixel_clk);
      start = 1'b0;
      abort = 1'b0;
      if (bus.gpu_we === 1'b1) begin
        if (last_we >= 0 && last_we != c - 1) cap_gaps++;
        if (cap_first_we < 0) cap_first_we = c;
        last_we = c;
        cap_din.push_back(bus.gpu_din);
        cap_addr.push_back(bus.mem_addr);
        if (cap_din.size() == start_we) start = 1'b1;
        if (cap_din.size() == abort_we) abort = 1'b1;
      end
      if (done === 1'b1) begin
        cap_done++;
        if (cap_done_at < 0) cap_done_at = c;
        if (start_on_done) start = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    cap_end_busy = busy;
    cap_end_we   = bus.gpu_we;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pixel_clk);
    n_cmp++;
    if (bus.gpu_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_state: we=%b busy=%b done=%b addr=%h, expected 0/0/0/0000",
               bus.gpu_we, busy, done, bus.mem_addr);
    end
`ifdef LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_checksum: got %h expected 0000", checksum);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_full_burst(input string name, input logic [ADDR_W-1:0] b);
    int bad_din, bad_addr, first_k;
    logic [15:0] act_w, exp_w;
    launch(b);
    n_cmp++;
    if (busy !== 1'b1 || bus.gpu_we !== 1'b0 || bus.mem_addr !== b) begin
      n_bad++;
      $display("FAIL %s fetch: busy=%b we=%b addr=%h, expected 1/0/%h",
               name, busy, bus.gpu_we, bus.mem_addr, b);
    end
    capture(WORDS + 8, -1, 1'b0, -1);
    n_cmp++;
    if (cap_din.size() != WORDS || cap_gaps != 0) begin
      n_bad++;
      $display("FAIL %s we_count: got %0d words %0d gaps, expected %0d words 0 gaps",
               name, cap_din.size(), cap_gaps, WORDS);
    end
    n_cmp++;
    if (cap_first_we != 0 || cap_done_at != WORDS || cap_done != 1) begin
      n_bad++;
      $display("FAIL %s latency: first_we=%0d done_at=%0d dones=%0d, expected 0/%0d/1",
               name, cap_first_we, cap_done_at, cap_done, WORDS);
    end
    n_cmp++;
    if (cap_end_busy !== 1'b0 || cap_end_we !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: busy=%b we=%b, expected 0/0", name, cap_end_busy, cap_end_we);
    end
    bad_din = 0; bad_addr = 0; first_k = -1; act_w = '0; exp_w = '0;
    for (int k = 0; k < cap_din.size() && k < WORDS; k++) begin
      if (cap_din[k] !== exp_word(b, k)) begin
        if (first_k < 0) begin first_k = k; act_w = cap_din[k]; exp_w = exp_word(b, k); end
        bad_din++;
      end
      if (k < WORDS - 1 && cap_addr[k] !== ADDR_W'(b + ADDR_W'(k + 1))) bad_addr++;
    end
    n_cmp++;
    if (bad_din != 0) begin
      n_bad++;
      $display("FAIL %s data: %0d bad words, word %0d got %h expected %h",
               name, bad_din, first_k, act_w, exp_w);
    end
    n_cmp++;
    if (bad_addr != 0) begin
      n_bad++;
      $display("FAIL %s mem_addr: %0d cycles with wrong address, expected 0", name, bad_addr);
    end
`ifdef LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== exp_sum(b, WORDS)) begin
      n_bad++;
      $display("FAIL %s checksum: got %h expected %h", name, checksum, exp_sum(b, WORDS));
    end
`endif
  endtask

  task automatic test_basic();
    fill_ramp();
    test_full_burst("basic", '0);
    n_cmp++;
    if (cap_din.size() != WORDS || cap_din[0] !== 16'h0100 || cap_din[WORDS-1] !== 16'h027F) begin
      n_bad++;
      $display("FAIL basic_ends: got %0d words, expected first 0100 last 027F", cap_din.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      fill_random();
      test_full_burst("random", ADDR_W'($urandom));
    end
  endtask

  task automatic test_wrap();
    fill_random();
    test_full_burst("wrap", 16'hFF00);
    n_cmp++;
    if (cap_addr.size() != WORDS || cap_addr[254] !== 16'hFFFF || cap_addr[255] !== 16'h0000
        || cap_addr[WORDS-2] !== 16'h007F) begin
      n_bad++;
      $display("FAIL wrap_addr: got %0d samples, expected FFFF->0000 wrap ending at 007F",
               cap_addr.size());
    end
  endtask

  task automatic test_ignored_start();
    logic [ADDR_W-1:0] b, held;
    int bad;
    fill_random();
    b = ADDR_W'($urandom);
    launch(b);
    capture(WORDS + 10, 10, 1'b1, -1);
    bad = 0;
    for (int k = 0; k < cap_din.size() && k < WORDS; k++)
      if (cap_din[k] !== exp_word(b, k)) bad++;
    n_cmp++;
    if (cap_din.size() != WORDS || cap_done != 1 || bad != 0 || cap_end_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start: words=%0d dones=%0d bad=%0d busy=%b, expected %0d/1/0/0",
               cap_din.size(), cap_done, bad, cap_end_busy, WORDS);
    end
    held = bus.mem_addr;
    @(negedge pixel_clk);
    start = 1'b1; cpu_idle = 1'b0; base_addr = held + ADDR_W'(16'h1234);
    bad = 0;
    repeat (3) begin
      @(negedge pixel_clk);
      if (bus.mem_addr !== held || bus.gpu_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    start = 1'b0; cpu_idle = 1'b1;
    repeat (3) begin
      @(negedge pixel_clk);
      if (bus.mem_addr !== held || bus.gpu_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL cpu_busy_start: %0d cycles moved, expected 0", bad);
    end
  endtask

  task automatic test_abort();
    logic [ADDR_W-1:0] b;
    int bad;
    fill_random();
    b = ADDR_W'($urandom);
    launch(b);
    capture(WORDS + 8, -1, 1'b0, 100);
    bad = 0;
    for (int k = 0; k < cap_din.size(); k++)
      if (cap_din[k] !== exp_word(b, k)) bad++;
    n_cmp++;
    if (cap_din.size() != 100 || cap_done != 0 || bad != 0) begin
      n_bad++;
      $display("FAIL abort_mid: words=%0d dones=%0d bad=%0d, expected 100/0/0",
               cap_din.size(), cap_done, bad);
    end
    n_cmp++;
    if (cap_end_busy !== 1'b0 || cap_end_we !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b we=%b, expected 0/0", cap_end_busy, cap_end_we);
    end
`ifdef LOADER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== exp_sum(b, 100)) begin
      n_bad++;
      $display("FAIL abort_checksum: got %h expected %h", checksum, exp_sum(b, 100));
    end
`endif
    b = ADDR_W'($urandom);
    launch(b);
    capture(WORDS + 8, -1, 1'b0, WORDS);
    n_cmp++;
    if (cap_din.size() != WORDS || cap_done != 0 || cap_end_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_last: words=%0d dones=%0d busy=%b, expected %0d/0/0",
               cap_din.size(), cap_done, cap_end_busy, WORDS);
    end
    @(negedge pixel_clk);
    abort = 1'b1;
    repeat (2) @(negedge pixel_clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_in_idle: busy=%b done=%b, expected 0/0", busy, done);
    end
    test_full_burst("after_abort", ADDR_W'($urandom));
  endtask

  task automatic test_async_reset();
    fill_random();
    launch(ADDR_W'($urandom));
    repeat (50) @(negedge pixel_clk);
    @(posedge pixel_clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.gpu_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.mem_addr !== '0) begin
      n_bad++;
      $display("FAIL async_reset: we=%b busy=%b done=%b addr=%h, expected 0/0/0/0000",
               bus.gpu_we, busy, done, bus.mem_addr);
    end
    @(negedge pixel_clk);
    reset = 1'b0;
    test_full_burst("after_reset", ADDR_W'($urandom));
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    fill_const(16'h0001);
    test_full_burst("sum_ones", ADDR_W'($urandom));
    n_cmp++;
    if (checksum !== 16'h0180) begin
      n_bad++;
      $display("FAIL checksum_ones: got %h expected 0180", checksum);
    end
    fill_const(16'hFFFF);
    test_full_burst("sum_ffff", ADDR_W'($urandom));
    n_cmp++;
    if (checksum !== 16'hFE80) begin
      n_bad++;
      $display("FAIL checksum_ffff: got %h expected FE80", checksum);
    end
  endtask
`endif

  initial begin
    fill_const(16'h0000);
    test_reset();
    test_basic();
    test_random();
    test_wrap();
    test_ignored_start();
    test_abort();
    test_async_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
